iir_deemph: RTL and testbench

IIR_DEEMPH -- requirements
Module: iir_deemph

---
 rtl/iir_deemph_pkg.sv | 34 +++
 rtl/iir_deemph.sv | 107 ++++++++++
 tb/tb_iir_deemph.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_deemph_pkg.sv
// Shared definitions for the audio chain: stage FSM states, quantization defaults
// and the dequantize helper used by the FIR, demod, gain and de-emphasis stages.
package iir_deemph_pkg;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MUL   = 2'd1,
    S_SUM   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam int DEF_BITS = 10;

  // De-emphasis coefficients in Q(BITS); a1 already carries the feedback sign.
  localparam logic [31:0] DEF_X_COEFF0 = 32'h000000B2;
  localparam logic [31:0] DEF_X_COEFF1 = 32'h000000B2;
  localparam logic [31:0] DEF_Y_COEFF1 = 32'h0000029C;

  // Products of samples up to 64 bits wide are dequantized at this width.
  localparam int DQ_W = 128;

  // Arithmetic right shift by bits, rounding toward zero.
  function automatic logic signed [DQ_W-1:0] dq(input logic signed [DQ_W-1:0] p,
                                                input int bits);
    logic signed [DQ_W-1:0] bias;
    bias = (DQ_W'(1) <<< bits) - DQ_W'(1);
    if (p[DQ_W-1]) begin
      dq = (p + bias) >>> bits;
    end else begin
      dq = p >>> bits;
    end
  endfunction

endpackage

// File: rtl/iir_deemph.sv
// First-order IIR de-emphasis stage between two FIFOs:
// y[n] = DQ(b0*x[n]) + DQ(b1*x[n-1]) + DQ(a1*y[n-1]), one sample per four cycles.
module iir_deemph
  import iir_deemph_pkg::*;
#(
  parameter int                            DATA_WIDTH = 32,
  parameter int                            BITS       = DEF_BITS,
  parameter logic signed [DATA_WIDTH-1:0]  X_COEFF0   = DATA_WIDTH'(DEF_X_COEFF0),
  parameter logic signed [DATA_WIDTH-1:0]  X_COEFF1   = DATA_WIDTH'(DEF_X_COEFF1),
  parameter logic signed [DATA_WIDTH-1:0]  Y_COEFF1   = DATA_WIDTH'(DEF_Y_COEFF1)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  state_t state_reg;
  state_t state_next;

  logic signed [DATA_WIDTH-1:0] x_reg;
  logic signed [DATA_WIDTH-1:0] x1_reg;
  logic signed [DATA_WIDTH-1:0] y_reg;
  logic signed [DATA_WIDTH-1:0] y1_reg;
  logic signed [PROD_W-1:0]     p0_reg;
  logic signed [PROD_W-1:0]     p1_reg;
  logic signed [PROD_W-1:0]     p2_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_READ;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_READ:  if (!in_empty) state_next = S_MUL;
      S_MUL:   state_next = S_SUM;
      S_SUM:   state_next = S_WRITE;
      S_WRITE: if (!out_full) state_next = S_READ;
      default: state_next = S_READ;
    endcase
  end

  // Handshakes are gated by reset so nothing leaves the block while it is held.
  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    out_din   = '0;
    if (!reset) begin
      in_rd_en  = (state_reg == S_READ) && !in_empty;
      out_wr_en = (state_reg == S_WRITE) && !out_full;
      if (out_wr_en) begin
        out_din = y_reg;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_reg  <= '0;
      x1_reg <= '0;
      y_reg  <= '0;
      y1_reg <= '0;
      p0_reg <= '0;
      p1_reg <= '0;
      p2_reg <= '0;
    end else begin
      case (state_reg)
        S_READ: begin
          if (!in_empty) begin
            x_reg <= in_dout;
          end
        end
        S_MUL: begin
          p0_reg <= PROD_W'(x_reg)  * PROD_W'(X_COEFF0);
          p1_reg <= PROD_W'(x1_reg) * PROD_W'(X_COEFF1);
          p2_reg <= PROD_W'(y1_reg) * PROD_W'(Y_COEFF1);
        end
        S_SUM: begin
          // Sum wraps to the sample width; no saturation.
          y_reg <= DATA_WIDTH'(dq(DQ_W'(p0_reg), BITS)
                             + dq(DQ_W'(p1_reg), BITS)
                             + dq(DQ_W'(p2_reg), BITS));
        end
        S_WRITE: begin
          // History advances only when the output actually leaves.
          if (!out_full) begin
            x1_reg <= x_reg;
            y1_reg <= y_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_deemph.sv
// Bench for iir_deemph: FIFO-style source/sink, a difference-equation model
// checked every cycle, and directed tests with hand-computed outputs.
module tb_iir_deemph;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_rd_en;
  logic        in_empty = 1'b1;
  logic [31:0] in_dout = '0;
  logic        out_wr_en;
  logic        out_full = 1'b0;
  logic [31:0] out_din;

  iir_deemph dut (
    .clock     (clock),
    .reset     (reset),
    .in_rd_en  (in_rd_en),
    .in_empty  (in_empty),
    .in_dout   (in_dout),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .out_din   (out_din)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int src_q[$];
  int exp_q[$];
  int out_log[$];
  int rd_count = 0;
  int wr_count = 0;
  int popped   = 0;
  bit rand_mode = 1'b0;
  bit full_req  = 1'b0;
  bit starve    = 1'b0;

  longint m_x1 = 0;
  longint m_y1 = 0;

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Integer division truncates toward zero, which is exactly the DQ rounding rule.
  function automatic longint dqm(input longint p);
    return p / 1024;
  endfunction

  task automatic model_consume(input int x);
    longint y;
    int     y32;
    y   = dqm(178 * longint'(x)) + dqm(178 * m_x1) + dqm(668 * m_y1);
    y32 = int'(y);
    m_x1 = x;
    m_y1 = y32;
    exp_q.push_back(y32);
  endtask

  // Source/sink driver: pops consumed samples, presents the FIFO head.
  always @(posedge clock) begin
    #2;
    while (popped < rd_count && src_q.size() > 0) begin
      void'(src_q.pop_front());
      popped++;
    end
    popped = rd_count;
    if (rand_mode) begin
      starve   = ($urandom_range(0, 1) == 1);
      out_full = full_req || ($urandom_range(0, 3) == 0);
    end else begin
      starve   = 1'b0;
      out_full = full_req;
    end
    in_empty = starve || (src_q.size() == 0);
    in_dout  = (src_q.size() > 0) ? src_q[0] : 0;
  end

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    chk("rd_wr_exclusive", {in_rd_en, out_wr_en} == 2'b11, 0);
    if (reset) begin
      chk("reset_quiet", {in_rd_en, out_wr_en, out_din}, 0);
      exp_q.delete();
      m_x1 = 0;
      m_y1 = 0;
    end else begin
      if (out_wr_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %0d want none", $signed(out_din));
        end else begin
          $display("write #%0d out=%0d exp=%0d", wr_count, $signed(out_din), exp_q[0]);
          chk("out_din", $signed(out_din), exp_q.pop_front());
        end
        out_log.push_back($signed(out_din));
        wr_count++;
      end else begin
        chk("out_din_idle_zero", out_din, 0);
      end
      if (in_rd_en) begin
        if (src_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL read_from_empty: got rd_en=1 want 0");
        end else begin
          model_consume(src_q[0]);
        end
        rd_count++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    src_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int cyc = 0;
    while (out_log.size() < n && cyc < budget) begin
      @(posedge clock);
      cyc++;
    end
    if (out_log.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d writes want %0d", name, out_log.size(), n);
    end
  endtask

  function automatic int log_at(input int i);
    return (i < out_log.size()) ? out_log[i] : 32'h7fffffff;
  endfunction

  initial begin
    int wr0;
    int rd0;
    int s;
    bit wrapped;

    // Reset held; sample waiting so the first post-reset cycle can read.
    repeat (3) @(posedge clock);
    src_q.push_back(1024);
    src_q.push_back(0);
    src_q.push_back(0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rd_first_cycle_after_reset", in_rd_en, 1);

    // Impulse
    out_log.delete();
    wait_writes("impulse", 3, 100);
    chk("impulse_y0", log_at(0), 178);
    chk("impulse_y1", log_at(1), 294);
    chk("impulse_y2", log_at(2), 191);

    // Negative impulse
    do_reset();
    out_log.delete();
    src_q.push_back(-1024);
    src_q.push_back(0);
    wait_writes("neg_impulse", 2, 100);
    chk("neg_impulse_y0", log_at(0), -178);
    chk("neg_impulse_y1", log_at(1), -294);

    // Back-pressure: the block parks in the write state while full.
    do_reset();
    out_log.delete();
    full_req = 1'b1;
    wr0 = wr_count;
    rd0 = rd_count;
    src_q.push_back(1024);
    src_q.push_back(0);
    repeat (16) @(posedge clock);
    chk("bp_no_write", wr_count - wr0, 0);
    chk("bp_single_read", rd_count - rd0, 1);
    #1 full_req = 1'b0;
    wait_writes("backpressure", 2, 100);
    chk("bp_first", log_at(0), 178);
    chk("bp_second", log_at(1), 294);

    // Reset while the sum is in flight: sample is dropped and history cleared.
    do_reset();
    out_log.delete();
    wr0 = wr_count;
    rd0 = rd_count;
    src_q.push_back(1024);
    begin
      int cyc = 0;
      while (rd_count == rd0 && cyc < 50) begin
        @(negedge clock);
        cyc++;
      end
    end
    chk("reset_mid_read_seen", rd_count - rd0, 1);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_mid_no_write", wr_count - wr0, 0);
    src_q.push_back(0);
    wait_writes("reset_mid", 1, 100);
    chk("reset_mid_out", log_at(0), 0);

    // DC step
    do_reset();
    out_log.delete();
    for (int i = 0; i < 64; i++) src_q.push_back(1024);
    wait_writes("dc", 64, 2000);
    wrapped = 1'b0;
    for (int i = 0; i < out_log.size(); i++)
      if (out_log[i] < 0 || out_log[i] > 1100) wrapped = 1'b1;
    chk("dc_no_wrap", wrapped, 0);
    total++;
    if (log_at(63) < 1020 || log_at(63) > 1028) begin
      bad++;
      $display("FAIL dc_final: got %0d want 1024+/-4", log_at(63));
    end

    // Starvation and random back-pressure with random samples
    do_reset();
    out_log.delete();
    wr0 = wr_count;
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      s = int'($urandom_range(0, 200000)) - 100000;
      src_q.push_back(s);
    end
    wait_writes("random", 200, 20000);
    rand_mode = 1'b0;
    repeat (10) @(posedge clock);
    chk("random_write_count", wr_count - wr0, 200);
    chk("random_exp_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "global timeout");
  end

endmodule
